// File: rtl/ps2_move_decoder_pkg.sv
// Shared definitions for the PS/2 move decoder: move command codes,
// scan-code set 2 constants, receiver states and the key lookup.
package ps2_move_decoder_pkg;

    // Move command codes, as consumed by the game logic
    localparam logic [2:0] MV_NONE  = 3'd0;
    localparam logic [2:0] MV_UP    = 3'd1;
    localparam logic [2:0] MV_DOWN  = 3'd2;
    localparam logic [2:0] MV_LEFT  = 3'd3;
    localparam logic [2:0] MV_RIGHT = 3'd4;
    localparam logic [2:0] MV_PLAY  = 3'd5;
    localparam logic [2:0] MV_RESET = 3'd6;

    // Scan-code set 2 prefixes
    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;

    // Plain key codes
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_R     = 8'h2D;

    // Extended (E0-prefixed) arrow key codes
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Translate (ext, code) to a move command; MV_NONE for unmapped keys
    function automatic logic [2:0] map_key(input logic ext, input logic [7:0] code);
        logic [2:0] m;
        m = MV_NONE;
        if (ext) begin
            case (code)
                SC_UP:    m = MV_UP;
                SC_DOWN:  m = MV_DOWN;
                SC_LEFT:  m = MV_LEFT;
                SC_RIGHT: m = MV_RIGHT;
                default:  m = MV_NONE;
            endcase
        end else begin
            case (code)
                SC_W:     m = MV_UP;
                SC_S:     m = MV_DOWN;
                SC_A:     m = MV_LEFT;
                SC_D:     m = MV_RIGHT;
                SC_SPACE: m = MV_PLAY;
                SC_R:     m = MV_RESET;
                default:  m = MV_NONE;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_move_decoder_rx.sv
// PS/2 frame receiver: 2-FF synchronisers, ps2_clk glitch filter,
// start/data/parity/stop framing and a mid-frame inactivity timeout.
// Produces one byte_valid pulse per good frame, frame_err per bad one.
import ps2_move_decoder_pkg::*;

module ps2_move_decoder_rx #(
    parameter int FILTER_CYC  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          s_clk;
    logic          s_data;
    logic          filt;
    logic [FW-1:0] filt_cnt;
    logic          settle;
    logic          strobe;
    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] to_cnt;

    assign s_clk  = clk_sync[1];
    assign s_data = data_sync[1];

    // The filtered level flips on the FILTER_CYC-th consecutive differing
    // sample; a 1->0 flip is the sample strobe for the frame FSM.
    assign settle = (s_clk != filt) && (filt_cnt == FW'(FILTER_CYC - 1));
    assign strobe = settle && filt;

    // Synchronisers idle high like the PS/2 bus so reset never fakes an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Glitch filter on the synchronised ps2_clk
    always_ff @(posedge clk) begin
        if (rst) begin
            filt     <= 1'b1;
            filt_cnt <= '0;
        end else if (s_clk == filt) begin
            filt_cnt <= '0;
        end else if (settle) begin
            filt     <= s_clk;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Frame FSM with timeout; outputs are single-cycle registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            to_cnt     <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (state == RX_IDLE || strobe) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (state != RX_IDLE && !strobe && to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                state     <= RX_IDLE;
                frame_err <= 1'b1;
            end else if (strobe) begin
                case (state)
                    RX_IDLE: begin
                        if (!s_data) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    RX_DATA: begin
                        shreg <= {s_data, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
                            state <= RX_PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    RX_PARITY: begin
                        par   <= s_data;
                        state <= RX_STOP;
                    end
                    RX_STOP: begin
                        state <= RX_IDLE;
                        if (s_data && (^{shreg, par})) begin
                            rx_byte    <= shreg;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard to Sokoban move command decoder. Tracks E0/F0 prefixes,
// keeps a held-key bitmap so a held key produces a single move pulse.
// Optional macro TYPEMATIC_EN: every make code (including keyboard
// auto-repeat) emits a move pulse.
import ps2_move_decoder_pkg::*;

module ps2_move_decoder #(
    parameter int FILTER_CYC  = 8,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [2:0] move,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_err;
    logic       ext;
    logic       brk;
    logic [6:0] held;
    logic [2:0] key;

    ps2_move_decoder_rx #(
        .FILTER_CYC (FILTER_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (rx_err)
    );

    assign key       = map_key(ext, rx_byte);
    assign frame_err = rx_err;

    // Prefix tracking, held bitmap and single-cycle move pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            move <= MV_NONE;
            ext  <= 1'b0;
            brk  <= 1'b0;
            held <= '0;
        end else begin
            move <= MV_NONE;
            if (rx_err) begin
                // a broken frame must not leave a dangling prefix
                ext <= 1'b0;
                brk <= 1'b0;
            end else if (rx_valid) begin
                if (rx_byte == SC_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == SC_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (key != MV_NONE) begin
                        if (brk) begin
                            held[key] <= 1'b0;
                        end else begin
`ifdef TYPEMATIC_EN
                            move <= key;
`else
                            if (!held[key]) begin
                                move <= key;
                            end
`endif
                            held[key] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Scoreboard bench for ps2_move_decoder: expected {frame_err, move} events
// are queued as frames are sent and popped whenever the DUT pulses.
module tb_ps2_move_decoder;

    localparam int FILT = 8;
    localparam int TO   = 3000;
    localparam int HALF = 20;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [2:0] move;
    logic       frame_err;

    int n_vec;
    int n_err;
    logic [3:0] exp_q[$];

    ps2_move_decoder #(
        .FILTER_CYC (FILT),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .move     (move),
        .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive the first nbits of a frame; glitch_bit >= 0 adds a short
    // low pulse on ps2_clk while that bit's clock is high.
    task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int glitch_bit, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            if (i == glitch_bit) begin
                cyc(5);
                ps2_clk = 1'b0;
                cyc(3);
                ps2_clk = 1'b1;
                cyc(HALF - 8);
            end else begin
                cyc(HALF);
            end
            ps2_clk = 1'b0;
            cyc(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 1'b0, 1'b0, -1, 11);
        cyc(3 * HALF);
    endtask

    task automatic expect_ev(input logic err, input logic [2:0] m);
        exp_q.push_back({err, m});
    endtask

    task automatic drain(input string tag);
        cyc(4 * HALF);
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Every pulse must match the next queued event; extras are failures
    always @(negedge clk) begin
        if (!rst && (move != 3'd0 || frame_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected", {frame_err, move}, 4'h0);
            end else begin
                chk("event", {frame_err, move}, exp_q.pop_front());
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish, queue=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cyc(5);
        @(negedge clk);
        chk("rst_move", move, 3'd0);
        chk("rst_err", frame_err, 1'b0);
        rst = 1'b0;
        cyc(5);

        // plain make then break
        expect_ev(1'b0, 3'd1);
        send(8'h1D); send(8'hF0); send(8'h1D);
        drain("up");

        // extended LEFT, typematic repeat, extended break
        expect_ev(1'b0, 3'd3);
`ifdef TYPEMATIC_EN
        expect_ev(1'b0, 3'd3);
`endif
        send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'hF0); send(8'h6B);
        drain("left");

        // after release a new press pulses again
        expect_ev(1'b0, 3'd3);
        send(8'hE0); send(8'h6B);
        send(8'hE0); send(8'hF0); send(8'h6B);
        drain("left_again");

        // two keys held together, other extended arrows
        expect_ev(1'b0, 3'd1);
        expect_ev(1'b0, 3'd4);
        expect_ev(1'b0, 3'd2);
        send(8'h1D); send(8'h23);
        send(8'hE0); send(8'h72);
        send(8'hF0); send(8'h1D); send(8'hF0); send(8'h23);
        send(8'hE0); send(8'hF0); send(8'h72);
        drain("multi");

        // bad parity then good frame
        expect_ev(1'b1, 3'd0);
        expect_ev(1'b0, 3'd5);
        send_bits(8'h29, 1'b1, 1'b0, -1, 11); cyc(3 * HALF);
        send(8'h29); send(8'hF0); send(8'h29);
        drain("parity");

        // bad stop after E0: prefix dropped, 72 alone is unmapped
        expect_ev(1'b1, 3'd0);
        send(8'hE0);
        send_bits(8'h72, 1'b0, 1'b1, -1, 11); cyc(3 * HALF);
        send(8'h72);
        drain("stop");

        // truncated frame times out, next frame decodes
        expect_ev(1'b1, 3'd0);
        expect_ev(1'b0, 3'd6);
        send_bits(8'h55, 1'b0, 1'b0, -1, 5);
        cyc(TO + 200);
        send(8'h2D); send(8'hF0); send(8'h2D);
        drain("timeout");

        // short ps2_clk glitch mid data is filtered out
        expect_ev(1'b0, 3'd2);
        send_bits(8'h1B, 1'b0, 1'b0, 3, 11); cyc(3 * HALF);
        send(8'hF0); send(8'h1B);
        drain("glitch");

        // unmapped code: no action
        send(8'h44);
        drain("unmapped");

        // reset after E0 and mid-frame: 75 decodes as plain unmapped
        send(8'hE0);
        send_bits(8'h33, 1'b0, 1'b0, -1, 4);
        rst = 1'b1;
        cyc(3);
        @(negedge clk);
        chk("rst2_move", move, 3'd0);
        rst = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        cyc(5);
        send(8'h75);
        drain("rst_prefix");

        // first good key after reset works
        expect_ev(1'b0, 3'd4);
        send(8'hE0); send(8'h74);
        drain("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
